imm_gen: RTL and testbench
==========================

IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 The block SHALL have exactly one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  rising-edge clock for the registered stage.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 in_valid  input  1  instr is valid this cycle; used only for capture into the registered stage.
REQ-007 imm  output  32  combinational sign-extended immediate of instr.
REQ-008 imm_fmt  output  3  combinational format code: NONE=0, I=1, S=2, B=3, U=4, J=5.
REQ-009 imm_ok  output  1  combinational; 1 when opcode is one of the eight recognised opcodes.
REQ-010 imm_q  output  32  registered imm.
REQ-011 imm_fmt_q  output  3  registered imm_fmt.
REQ-012 imm_ok_q  output  1  registered imm_ok.
REQ-013 out_valid  output  1  registered in_valid; qualifies imm_q, imm_fmt_q and imm_ok_q.

Function
REQ-014 The opcode SHALL be decoded from instr[6:0]; instr[1:0] SHALL participate in this compare, so there are no don't-cares.
REQ-015 U format (LUI 0110111, AUIPC 0010111) SHALL produce imm = {instr[31:12], 12'b0}.
- Example: 0xFEDCB037 -> 0xFEDCB000.
REQ-016 I format (JALR 1100111, LOAD 0000011, OP-IMM 0010011) SHALL produce imm = sign-extended instr[31:20].
- Shift-immediates SHALL receive no special treatment.
REQ-017 S format (STORE 0100011) SHALL produce imm = sign-extended {instr[31:25], instr[11:7]}.
REQ-018 B format (BRANCH 1100011) SHALL produce imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-019 J format (JAL 1101111) SHALL produce imm = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-020 Sign extension SHALL always replicate instr[31].
REQ-021 Any other opcode SHALL produce imm=0, imm_fmt=NONE and imm_ok=0.
- This covers OP, SYSTEM, MISC-MEM, all-zero and compressed-looking words.
REQ-022 imm, imm_fmt and imm_ok SHALL be purely combinational from instr.
- Zero latency, no dependence on clk, rst_n or in_valid.
REQ-023 On each rising clk edge with in_valid=1, imm_q, imm_fmt_q and imm_ok_q SHALL capture the combinational values; out_valid SHALL be set to 1.
REQ-024 On a rising edge with in_valid=0, imm_q, imm_fmt_q and imm_ok_q SHALL hold their values; out_valid SHALL be set to 0.
REQ-025 Registered-path latency SHALL be exactly one cycle; back-to-back valid words SHALL give one output per cycle, with no stall and no backpressure.

Reset
REQ-026 While rst_n=0, imm_q SHALL be 0, imm_fmt_q NONE, imm_ok_q 0 and out_valid 0.
- Reset SHALL take effect immediately, independent of clk, including mid-stream.
REQ-027 Combinational outputs SHALL continue to track instr during reset.
REQ-028 The first capture after reset SHALL occur on the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-029 A shared package (rv32_pkg) SHALL hold:
- the 7-bit opcode localparams;
- the imm_fmt enum typedef (3 bits);
- the per-format extraction functions.
REQ-030 Combinational decode SHALL be one sub-module, imm_decode (instr -> imm, imm_fmt, imm_ok); imm_gen SHALL instantiate it and add the register stage.

Verification
REQ-031 instr=0x12345037, 0x00001017, 0x7FFFF037 -> imm=0x12345000, 0x00001000, 0x7FFFF000 with imm_fmt=U.
REQ-032 I format:
- 0x00C00093 -> 0x0000000C; 0xFF400093 -> 0xFFFFFFF4; 0xFF8000E7 -> 0xFFFFFFF8;
- 0xFFC02083 -> 0xFFFFFFFC; 0x7FF00093 -> 0x000007FF; 0x80000093 -> 0xFFFFF800.
REQ-033 S format: 0x00102223 -> 0x00000004; 0xFE102E23 -> 0xFFFFFFFC.
- B format: 0x00100463 -> 0x00000008; 0xFE100EE3 -> 0xFFFFFFFC; 0x02101463 -> 0x00000028.
REQ-034 J format: 0x008000EF -> 0x00000008; 0xFF9FF0EF -> 0xFFFFFFF8; 0x100000EF -> 0x00000100.
- Unrecognised opcodes: 0x12345678 and 0x00000000 -> imm=0, imm_fmt=NONE, imm_ok=0.
REQ-035 Registered path: with in_valid=1 over consecutive cycles carrying 0x00C00093 then 0xFE100EE3, check the edge after each word:
- first edge: out_valid=1, imm_q=0x0000000C;
- second edge: out_valid=1, imm_q=0xFFFFFFFC.
- Then drop in_valid: imm_q holds 0xFFFFFFFC and out_valid=0.
REQ-036 Reset mid-stream: assert rst_n=0 between clock edges -> imm_q=0 and out_valid=0 immediately, while imm still equals decode(instr).

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcodes, immediate format codes and per-format immediate extraction.
package rv32_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // Full 7-bit compare: the two low bits are decoded too, so compressed words fall to NONE.
    function automatic imm_fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JALR, OP_LOAD, OP_IMM: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_NONE;
        endcase
    endfunction
endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational RV32I immediate extraction and format classification.
module imm_decode
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic [2:0]  imm_fmt,
    output logic        imm_ok
);
    imm_fmt_e fmt;

    always_comb begin
        fmt     = fmt_of(instr[6:0]);
        imm     = fmt == FMT_I ? imm_i(instr) :
                  fmt == FMT_S ? imm_s(instr) :
                  fmt == FMT_B ? imm_b(instr) :
                  fmt == FMT_U ? imm_u(instr) :
                  fmt == FMT_J ? imm_j(instr) : 32'd0;
        imm_fmt = fmt;
        imm_ok  = fmt != FMT_NONE;
    end
endmodule

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate generator with combinational outputs and a one-cycle registered copy.
module imm_gen
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic [31:0] imm,
    output logic [2:0]  imm_fmt,
    output logic        imm_ok,
    output logic [31:0] imm_q,
    output logic [2:0]  imm_fmt_q,
    output logic        imm_ok_q,
    output logic        out_valid
);
    imm_decode u_dec (
        .instr  (instr),
        .imm    (imm),
        .imm_fmt(imm_fmt),
        .imm_ok (imm_ok)
    );

    // Payload holds when in_valid is low; only out_valid follows every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q     <= 32'd0;
            imm_fmt_q <= FMT_NONE;
            imm_ok_q  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                imm_q     <= imm;
                imm_fmt_q <= imm_fmt;
                imm_ok_q  <= imm_ok;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: randomized and directed checks of imm_gen against an arithmetic reference model.
module tb_imm_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        in_valid = 1'b0;
    logic [31:0] imm, imm_q;
    logic [2:0]  imm_fmt, imm_fmt_q;
    logic        imm_ok, imm_ok_q, out_valid;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] exp_imm_q = 32'd0;
    logic [2:0]  exp_fmt_q = 3'd0;
    logic        exp_ok_q = 1'b0;

    imm_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .in_valid (in_valid),
        .imm      (imm),
        .imm_fmt  (imm_fmt),
        .imm_ok   (imm_ok),
        .imm_q    (imm_q),
        .imm_fmt_q(imm_fmt_q),
        .imm_ok_q (imm_ok_q),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Immediate value built as a signed integer from the field weights, then wrapped to 32 bits.
    function automatic void model(input logic [31:0] w, output logic [31:0] m_imm,
                                  output logic [2:0] m_fmt);
        int v;
        v = 0;
        m_fmt = 3'd0;
        case (w[6:0])
            7'h37, 7'h17: begin m_fmt = 3'd4; v = int'(w[31:12]) * 4096; end
            7'h67, 7'h03, 7'h13: begin
                m_fmt = 3'd1;
                v = int'(w[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                m_fmt = 3'd2;
                v = int'(w[31:25]) * 32 + int'(w[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                m_fmt = 3'd3;
                v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h6F: begin
                m_fmt = 3'd5;
                v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                    + int'(w[30:21]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        m_imm = 32'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [8] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(7)];
        return w;
    endfunction

    task automatic check_comb(input string tag);
        logic [31:0] e_imm;
        logic [2:0]  e_fmt;
        model(instr, e_imm, e_fmt);
        n_checks++;
        if (imm !== e_imm || imm_fmt !== e_fmt || imm_ok !== (e_fmt != 3'd0)) begin
            n_fail++;
            $display("FAIL %s instr=%08h got imm=%08h fmt=%0d ok=%b exp imm=%08h fmt=%0d ok=%b",
                     tag, instr, imm, imm_fmt, imm_ok, e_imm, e_fmt, e_fmt != 3'd0);
        end
    endtask

    task automatic test_reset();
        instr = 32'hFEDCB037;
        #3;
        n_checks++;
        if (imm_q !== 32'd0 || imm_fmt_q !== 3'd0 || imm_ok_q !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got imm_q=%08h fmt_q=%0d ok_q=%b ov=%b exp all zero",
                     imm_q, imm_fmt_q, imm_ok_q, out_valid);
        end
        n_checks++;
        if (imm !== 32'hFEDCB000) begin
            n_fail++;
            $display("FAIL reset_comb got imm=%08h exp FEDCB000", imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] vin  [22] = '{32'h12345037, 32'h00001017, 32'h7FFFF037, 32'h00C00093,
                                   32'hFF400093, 32'hFF8000E7, 32'hFFC02083, 32'h7FF00093,
                                   32'h80000093, 32'h00102223, 32'hFE102E23, 32'h00100463,
                                   32'hFE100EE3, 32'h02101463, 32'h008000EF, 32'hFF9FF0EF,
                                   32'h100000EF, 32'h12345678, 32'h00000000, 32'hFEDCB037,
                                   32'h00000073, 32'h00000033};
        logic [31:0] vexp [22] = '{32'h12345000, 32'h00001000, 32'h7FFFF000, 32'h0000000C,
                                   32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h000007FF,
                                   32'hFFFFF800, 32'h00000004, 32'hFFFFFFFC, 32'h00000008,
                                   32'hFFFFFFFC, 32'h00000028, 32'h00000008, 32'hFFFFFFF8,
                                   32'h00000100, 32'h00000000, 32'h00000000, 32'hFEDCB000,
                                   32'h00000000, 32'h00000000};
        logic [2:0]  vfmt [22] = '{4, 4, 4, 1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 3, 5, 5, 5, 0, 0, 4, 0, 0};
        for (int i = 0; i < 22; i++) begin
            instr = vin[i];
            #1;
            n_checks++;
            if (imm !== vexp[i] || imm_fmt !== vfmt[i] || imm_ok !== (vfmt[i] != 3'd0)) begin
                n_fail++;
                $display("FAIL directed[%0d] instr=%08h got imm=%08h fmt=%0d ok=%b exp imm=%08h fmt=%0d",
                         i, vin[i], imm, imm_fmt, imm_ok, vexp[i], vfmt[i]);
            end
        end
    endtask

    task automatic test_random_comb();
        for (int i = 0; i < 300; i++) begin
            instr = rand_instr();
            #1;
            check_comb("random_comb");
        end
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        instr = 32'h00C00093; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || imm_q !== 32'h0000000C || imm_fmt_q !== 3'd1 || imm_ok_q !== 1'b1) begin
            n_fail++;
            $display("FAIL pipe_first got ov=%b imm_q=%08h fmt_q=%0d exp ov=1 imm_q=0000000C fmt_q=1",
                     out_valid, imm_q, imm_fmt_q);
        end
        @(negedge clk);
        instr = 32'hFE100EE3;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || imm_q !== 32'hFFFFFFFC || imm_fmt_q !== 3'd3) begin
            n_fail++;
            $display("FAIL pipe_second got ov=%b imm_q=%08h fmt_q=%0d exp ov=1 imm_q=FFFFFFFC fmt_q=3",
                     out_valid, imm_q, imm_fmt_q);
        end
        @(negedge clk);
        instr = 32'h12345037; in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || imm_q !== 32'hFFFFFFFC || imm_fmt_q !== 3'd3 || imm_ok_q !== 1'b1) begin
            n_fail++;
            $display("FAIL pipe_hold got ov=%b imm_q=%08h fmt_q=%0d exp ov=0 imm_q=FFFFFFFC fmt_q=3",
                     out_valid, imm_q, imm_fmt_q);
        end
        exp_imm_q = 32'hFFFFFFFC; exp_fmt_q = 3'd3; exp_ok_q = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_imm;
        logic [2:0]  e_fmt;
        logic        v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            instr = rand_instr();
            v = (i < 40) ? 1'b1 : 1'($urandom_range(1));
            in_valid = v;
            model(instr, e_imm, e_fmt);
            if (v) begin exp_imm_q = e_imm; exp_fmt_q = e_fmt; exp_ok_q = e_fmt != 3'd0; end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== v || imm_q !== exp_imm_q || imm_fmt_q !== exp_fmt_q || imm_ok_q !== exp_ok_q) begin
                n_fail++;
                $display("FAIL b2b[%0d] got ov=%b imm_q=%08h fmt_q=%0d ok_q=%b exp ov=%b imm_q=%08h fmt_q=%0d ok_q=%b",
                         i, out_valid, imm_q, imm_fmt_q, imm_ok_q, v, exp_imm_q, exp_fmt_q, exp_ok_q);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        instr = 32'hFF9FF0EF; in_valid = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imm_q !== 32'd0 || imm_fmt_q !== 3'd0 || imm_ok_q !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_regs got imm_q=%08h fmt_q=%0d ok_q=%b ov=%b exp all zero",
                     imm_q, imm_fmt_q, imm_ok_q, out_valid);
        end
        instr = rand_instr();
        #1;
        check_comb("midreset_comb");
        @(posedge clk); #1;
        n_checks++;
        if (imm_q !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_edge got imm_q=%08h ov=%b exp imm_q=00000000 ov=0", imm_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        instr = 32'h100000EF;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || imm_q !== 32'h00000100 || imm_fmt_q !== 3'd5) begin
            n_fail++;
            $display("FAIL first_after_reset got ov=%b imm_q=%08h fmt_q=%0d exp ov=1 imm_q=00000100 fmt_q=5",
                     out_valid, imm_q, imm_fmt_q);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_comb();
        test_pipeline();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
